// File: rtl/bus_master_arb.sv
// bus_master_arb: round-robin two-port register bus master with single-strobe access, ack wait and timeout
module bus_master_arb #(
  parameter int BUS_ADDR_WIDTH = 16,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_IN_WIDTH = BUS_ADDR_WIDTH + BUS_DATA_WIDTH + 4,
  parameter int BUS_OUT_WIDTH = BUS_DATA_WIDTH + 3,
  parameter int TIMEOUT = 16,
  parameter logic [BUS_DATA_WIDTH-1:0] ERR_DATA = '1
) (
  input  logic                      bus_clk,
  input  logic                      bus_reset_l,
  output logic [BUS_IN_WIDTH-1:0]   bus_in,
  input  logic [BUS_OUT_WIDTH-1:0]  bus_out,
  input  logic                      a_req,
  input  logic                      a_we,
  input  logic [BUS_ADDR_WIDTH-1:0] a_addr,
  input  logic [BUS_DATA_WIDTH-1:0] a_wr_data,
  output logic                      a_ack,
  output logic                      a_err,
  output logic [BUS_DATA_WIDTH-1:0] a_rd_data,
  input  logic                      b_req,
  input  logic                      b_we,
  input  logic [BUS_ADDR_WIDTH-1:0] b_addr,
  input  logic [BUS_DATA_WIDTH-1:0] b_wr_data,
  output logic                      b_ack,
  output logic                      b_err,
  output logic [BUS_DATA_WIDTH-1:0] b_rd_data,
  output logic                      irq,
  output logic [7:0]                timeout_cnt
);
  localparam int AW = BUS_ADDR_WIDTH;
  localparam int DW = BUS_DATA_WIDTH;
  localparam int BUS_FIELD_RD_ACK = DW;
  localparam int BUS_FIELD_WR_ACK = DW + 1;
  localparam int BUS_FIELD_IRQ = DW + 2;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic last_b_q, last_b_d, gnt_b_q, gnt_b_d, we_q, we_d, re_q, re_d, wstb_q, wstb_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, a_rd_q, a_rd_d, b_rd_q, b_rd_d, rdv;
  logic [7:0] cnt_q, cnt_d, tcnt_q, tcnt_d;
  logic a_ack_q, a_ack_d, a_err_q, a_err_d, b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic pick_b, ack_hit, done_go, err_go;
  assign bus_in = {bus_clk, bus_reset_l, re_q, wstb_q, addr_q, wdata_q};
  assign irq = bus_out[BUS_FIELD_IRQ];
  assign timeout_cnt = tcnt_q;
  assign a_ack = a_ack_q;
  assign a_err = a_err_q;
  assign a_rd_data = a_rd_q;
  assign b_ack = b_ack_q;
  assign b_err = b_err_q;
  assign b_rd_data = b_rd_q;
  always_comb begin
    pick_b = b_req && (!a_req || !last_b_q);
    ack_hit = we_q ? bus_out[BUS_FIELD_WR_ACK] : bus_out[BUS_FIELD_RD_ACK];
    state_d = state_q;
    last_b_d = last_b_q;
    gnt_b_d = gnt_b_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    re_d = 1'b0;
    wstb_d = 1'b0;
    cnt_d = cnt_q;
    done_go = 1'b0;
    err_go = 1'b0;
    case (state_q)
      IDLE: if (a_req || b_req) begin
        state_d = ISSUE;
        gnt_b_d = pick_b;
        last_b_d = pick_b;
        we_d = pick_b ? b_we : a_we;
        addr_d = (pick_b ? b_addr : a_addr) & ~AW'(3);
        wdata_d = pick_b ? b_wr_data : a_wr_data;
        re_d = !we_d;
        wstb_d = we_d;
      end
      ISSUE: begin
        cnt_d = 8'd1;
        done_go = ack_hit;
        state_d = ack_hit ? DONE : WAIT;
      end
      WAIT: begin
        err_go = !ack_hit && cnt_q == 8'(TIMEOUT);
        done_go = ack_hit || err_go;
        state_d = done_go ? DONE : WAIT;
        cnt_d = done_go ? cnt_q : cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    tcnt_d = (err_go && tcnt_q != 8'hFF) ? tcnt_q + 8'd1 : tcnt_q;
    rdv = err_go ? ERR_DATA : (we_q ? '0 : bus_out[DW-1:0]);
    a_ack_d = done_go && !gnt_b_q;
    a_err_d = a_ack_d && err_go;
    a_rd_d = a_ack_d ? rdv : '0;
    b_ack_d = done_go && gnt_b_q;
    b_err_d = b_ack_d && err_go;
    b_rd_d = b_ack_d ? rdv : '0;
  end
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      state_q <= IDLE;
      last_b_q <= 1'b1;
      gnt_b_q <= 1'b0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      wstb_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      tcnt_q <= '0;
      a_ack_q <= 1'b0;
      a_err_q <= 1'b0;
      a_rd_q <= '0;
      b_ack_q <= 1'b0;
      b_err_q <= 1'b0;
      b_rd_q <= '0;
    end else begin
      state_q <= state_d;
      last_b_q <= last_b_d;
      gnt_b_q <= gnt_b_d;
      we_q <= we_d;
      re_q <= re_d;
      wstb_q <= wstb_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      tcnt_q <= tcnt_d;
      a_ack_q <= a_ack_d;
      a_err_q <= a_err_d;
      a_rd_q <= a_rd_d;
      b_ack_q <= b_ack_d;
      b_err_q <= b_err_d;
      b_rd_q <= b_rd_d;
    end
  end
endmodule

// File: tb/tb_bus_master_arb.sv
// tb_bus_master_arb: random two-port traffic against a register-slave environment and a transaction-level arbiter model
module tb_bus_master_arb;
  localparam int TIMEOUT = 16;
  typedef struct {logic we; logic [15:0] addr; logic [31:0] data;} txn_t;
  logic bus_clk, rst_n;
  logic [51:0] bus_in;
  logic [34:0] bus_out;
  logic a_req, a_we, a_ack, a_err, b_req, b_we, b_ack, b_err, irq;
  logic [15:0] a_addr, b_addr;
  logic [31:0] a_wr_data, b_wr_data, a_rd_data, b_rd_data;
  logic [7:0] timeout_cnt;
  bus_master_arb dut (
    .bus_clk(bus_clk), .bus_reset_l(rst_n), .bus_in(bus_in), .bus_out(bus_out),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wr_data(a_wr_data),
    .a_ack(a_ack), .a_err(a_err), .a_rd_data(a_rd_data),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wr_data(b_wr_data),
    .b_ack(b_ack), .b_err(b_err), .b_rd_data(b_rd_data),
    .irq(irq), .timeout_cnt(timeout_cnt)
  );
  initial begin
    bus_clk = 0;
    forever #5 bus_clk = ~bus_clk;
  end
  function automatic int lat_of(logic [5:0] i);
    return (i == 16 || i == 32) ? 0 : (i == 17) ? 5 : int'(i) % 7;
  endfunction
  function automatic logic [31:0] init_val(logic [5:0] i);
    return (i == 16) ? 32'h1234 : (i == 32) ? 32'h1200 : 32'hA500_0000 | (32'(i) << 8) | 32'(i);
  endfunction
  // slave environment: 64 regs at 0x00-0xFC, upper half are mask regs, per-reg ack latency
  logic bus_re, bus_we, s_map, s_strobe, s_rd, s_wr, s_pend, s_pwe, stray, irq_drv;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata, s_dat;
  logic [31:0] s_mem [64];
  logic [5:0] s_ix, s_pix;
  int s_dly;
  int cyc = 0;
  assign bus_wdata = bus_in[31:0];
  assign bus_addr = bus_in[47:32];
  assign bus_we = bus_in[48];
  assign bus_re = bus_in[49];
  assign s_ix = bus_addr[7:2];
  assign s_map = bus_addr[15:8] == 8'h00;
  assign s_strobe = bus_re | bus_we;
  assign bus_out = {irq_drv, s_wr, s_rd, s_dat};
  always_comb begin
    s_rd = 0;
    s_wr = 0;
    s_dat = '0;
    if (s_strobe && s_map && lat_of(s_ix) == 0) begin
      s_rd = bus_re;
      s_wr = bus_we;
      s_dat = s_mem[s_ix];
    end
    if (s_pend && s_dly == lat_of(s_pix)) begin
      s_rd = !s_pwe;
      s_wr = s_pwe;
      s_dat = s_mem[s_pix];
    end
    if (stray && ((s_strobe && s_map) || s_pend)) begin
      if (s_strobe ? bus_we : s_pwe) s_rd = 1;
      else s_wr = 1;
    end
  end
  always @(posedge bus_clk) cyc <= cyc + 1;
  always @(posedge bus_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) s_mem[i] <= init_val(6'(i));
      s_pend <= 0;
      s_dly <= 0;
      s_pwe <= 0;
      s_pix <= '0;
    end else begin
      if (bus_we && s_map)
        s_mem[s_ix] <= s_ix[5] ? {s_mem[s_ix][31:16], (s_mem[s_ix][15:0] & ~bus_wdata[31:16]) | (bus_wdata[15:0] & bus_wdata[31:16])} : bus_wdata;
      if (s_strobe && s_map && lat_of(s_ix) != 0) begin
        s_pend <= 1;
        s_dly <= 1;
        s_pix <= s_ix;
        s_pwe <= bus_we;
      end else if (s_pend) begin
        if (s_dly == lat_of(s_pix)) s_pend <= 0;
        else s_dly <= s_dly + 1;
      end
    end
  end
  // reference model: one access at a time, timings derived from grant cycle and slave latency
  int n_chk = 0, n_bad = 0;
  txn_t qa[$], qb[$];
  bit ack_log[$];
  int ack_cyc[$];
  int p_req, stray_mode, idle_at, strobe_at, ack_at, gnt_cyc, m_tcnt;
  bit busy, m_port, m_last_b, m_we, exp_err;
  logic [15:0] m_addr;
  logic [31:0] m_wd, exp_rd, last_a_rd;
  logic last_a_err;
  logic [31:0] m_mem [64];
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    busy = 0;
    m_last_b = 1;
    m_tcnt = 0;
    for (int i = 0; i < 64; i++) m_mem[i] = init_val(6'(i));
  endtask
  task automatic push(bit port, logic we, logic [15:0] addr, logic [31:0] d);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.data = d;
    if (port) qb.push_back(t);
    else qa.push_back(t);
  endtask
  task automatic step();
    txn_t t;
    logic [5:0] idx;
    bit pick;
    @(negedge bus_clk);
    if (!rst_n) begin
      chk("rst_re", bus_re, 0);
      chk("rst_we", bus_we, 0);
      chk("rst_aack", a_ack, 0);
      chk("rst_back", b_ack, 0);
      chk("rst_tcnt", timeout_cnt, 0);
    end else begin
      if (busy && cyc == ack_at && exp_err) m_tcnt = (m_tcnt == 255) ? 255 : m_tcnt + 1;
      chk("re", bus_re, busy && cyc == strobe_at && !m_we);
      chk("we", bus_we, busy && cyc == strobe_at && m_we);
      if (busy && cyc == strobe_at) begin
        chk("addr", bus_addr, m_addr);
        if (m_we) chk("wdata", bus_wdata, m_wd);
      end
      chk("a_ack", a_ack, busy && cyc == ack_at && !m_port);
      chk("b_ack", b_ack, busy && cyc == ack_at && m_port);
      if (busy && cyc == ack_at) begin
        if (m_port) chk("b_err", b_err, exp_err);
        else chk("a_err", a_err, exp_err);
        if (!m_we || exp_err) begin
          if (m_port) chk("b_rd", b_rd_data, exp_rd);
          else chk("a_rd", a_rd_data, exp_rd);
        end
        busy = 0;
        idle_at = cyc + 1;
      end
      chk("irq", irq, irq_drv);
      chk("tcnt", timeout_cnt, m_tcnt);
    end
    if (a_ack) begin
      ack_log.push_back(0);
      ack_cyc.push_back(cyc);
      last_a_rd = a_rd_data;
      last_a_err = a_err;
    end
    if (b_ack) begin
      ack_log.push_back(1);
      ack_cyc.push_back(cyc);
    end
    if (a_req && a_ack) a_req = 0;
    if (b_req && b_ack) b_req = 0;
    if (!a_req && qa.size() > 0 && $urandom_range(99) < p_req) begin
      t = qa.pop_front();
      a_req = 1; a_we = t.we; a_addr = t.addr; a_wr_data = t.data;
    end
    if (!b_req && qb.size() > 0 && $urandom_range(99) < p_req) begin
      t = qb.pop_front();
      b_req = 1; b_we = t.we; b_addr = t.addr; b_wr_data = t.data;
    end
    stray = (stray_mode == 2) ? 1'b1 : (stray_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
    irq_drv = 1'($urandom_range(1));
    if (rst_n && !busy && cyc == idle_at) begin
      if (a_req || b_req) begin
        pick = b_req && (!a_req || !m_last_b);
        m_last_b = pick;
        m_port = pick;
        m_we = pick ? b_we : a_we;
        m_addr = (pick ? b_addr : a_addr) & 16'hFFFC;
        m_wd = pick ? b_wr_data : a_wr_data;
        gnt_cyc = cyc;
        strobe_at = cyc + 1;
        idx = m_addr[7:2];
        if (m_addr[15:8] == 0) begin
          ack_at = cyc + 2 + lat_of(idx);
          exp_err = 0;
          exp_rd = m_mem[idx];
          if (m_we) m_mem[idx] = idx[5] ? {m_mem[idx][31:16], (m_mem[idx][15:0] & ~m_wd[31:16]) | (m_wd[15:0] & m_wd[31:16])} : m_wd;
        end else begin
          ack_at = cyc + 2 + TIMEOUT;
          exp_err = 1;
          exp_rd = 32'hFFFF_FFFF;
        end
        busy = 1;
      end else idle_at = cyc + 1;
    end
  endtask
  task automatic drain(int budget);
    int n = 0;
    while (busy || a_req || b_req || qa.size() != 0 || qb.size() != 0) begin
      step();
      n++;
      if (n > budget) begin
        n_chk++;
        n_bad++;
        $display("FAIL drain_timeout cycles=%0d limit=%0d", n, budget);
        break;
      end
    end
  endtask
  task automatic release_reset();
    @(posedge bus_clk);
    #1 rst_n = 1;
    idle_at = cyc;
  endtask
  initial begin
    rst_n = 0;
    a_req = 0; a_we = 0; a_addr = '0; a_wr_data = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wr_data = '0;
    stray = 0; irq_drv = 0; stray_mode = 0; p_req = 100;
    model_reset();
    step();
    step();
    release_reset();
    push(0, 0, 16'h0040, 0);
    drain(50);
    chk("t1_rd", last_a_rd, 32'h1234);
    chk("t1_err", last_a_err, 0);
    chk("t1_lat", ack_cyc[$] - gnt_cyc, 2);
    push(1, 1, 16'h0080, 32'h00FF_00A5);
    drain(50);
    step();
    chk("t2_reg", s_mem[32], 32'h0000_12A5);
    ack_log.delete();
    ack_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 16'h0040, 0);
      push(1, 0, 16'h0080, 0);
    end
    drain(100);
    chk("t3_n", ack_log.size(), 8);
    for (int i = 0; i < ack_log.size(); i++) chk("t3_order", ack_log[i], i % 2);
    for (int i = 1; i < ack_cyc.size(); i++) chk("t3_gap", ack_cyc[i] - ack_cyc[i-1], 3);
    push(0, 0, 16'h0100, 0);
    drain(50);
    chk("t4_lat", ack_cyc[$] - gnt_cyc, 18);
    chk("t4_err", last_a_err, 1);
    chk("t4_rd", last_a_rd, 32'hFFFF_FFFF);
    chk("t4_tcnt", timeout_cnt, 1);
    for (int i = 0; i < 299; i++) push(0, 0, 16'h0100 | 16'(i), 0);
    drain(299 * 20 + 100);
    chk("t4_sat", timeout_cnt, 255);
    stray_mode = 2;
    push(0, 0, 16'h0044, 0);
    drain(50);
    chk("t5_lat", ack_cyc[$] - gnt_cyc, 7);
    chk("t5_err", last_a_err, 0);
    chk("t5_rd", last_a_rd, init_val(6'd17));
    stray_mode = 1;
    p_req = 60;
    for (int i = 0; i < 150; i++) begin
      push(0, 1'($urandom_range(1)), ($urandom_range(9) == 0) ? 16'h0100 | 16'($urandom_range(255)) : 16'($urandom_range(255)), $urandom);
      push(1, 1'($urandom_range(1)), ($urandom_range(9) == 0) ? 16'h0200 | 16'($urandom_range(255)) : 16'($urandom_range(255)), $urandom);
    end
    drain(300 * 25);
    p_req = 100;
    push(0, 0, 16'h0300, 0);
    for (int i = 0; i < 40 && !(busy && cyc >= strobe_at + 4); i++) step();
    #2 rst_n = 0;
    #1;
    chk("t6_re", bus_re, 0);
    chk("t6_we", bus_we, 0);
    chk("t6_addr", bus_addr, 0);
    chk("t6_aack", a_ack, 0);
    chk("t6_tcnt", timeout_cnt, 0);
    model_reset();
    step();
    step();
    release_reset();
    drain(50);
    chk("t6_regrant_err", last_a_err, 1);
    chk("t6_regrant_tcnt", timeout_cnt, 1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
